// File: rtl/kbd_scan_decoder.sv
// PS/2 set-2 scan-code decoder: pops bytes from the ps2_keyboard FIFO and tracks
// make/break/E0/typematic sequences, producing key code, ASCII, held flag and press count.
module kbd_scan_decoder #(
   parameter int COUNT_W     = 8,
   parameter bit ASCII_UPPER = 1'b0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [7:0]         kb_data,
   input  logic               kb_ready,
   input  logic               kb_overflow,
   output logic               kb_nextdata_n,
   output logic [7:0]         key_code,
   output logic               key_ext,
   output logic [7:0]         key_ascii,
   output logic               key_valid,
   output logic [COUNT_W-1:0] press_count,
   output logic               overflow_seen
);

   typedef enum logic [1:0] {S_IDLE, S_PROC, S_WAIT} state_t;

   localparam logic [7:0] BRK_CODE = 8'hF0;
   localparam logic [7:0] EXT_CODE = 8'hE0;

   state_t               state_q, state_d;
   logic [7:0]           byte_q, byte_d;
   logic                 brk_q, brk_d;
   logic                 ext_q, ext_d;
   logic                 nextdata_n_q, nextdata_n_d;
   logic [7:0]           key_code_q, key_code_d;
   logic                 key_ext_q, key_ext_d;
   logic [7:0]           key_ascii_q, key_ascii_d;
   logic                 key_valid_q, key_valid_d;
   logic [COUNT_W-1:0]   press_count_q, press_count_d;
   logic                 overflow_q, overflow_d;
   logic                 same_key;

   // Extended codes never map to ASCII; letters are offset from the selected case base.
   function automatic logic [7:0] ascii_of(input logic [7:0] code, input logic ext);
      logic [7:0] base;
      base = ASCII_UPPER ? 8'h41 : 8'h61;
      ascii_of = 8'h00;
      if (!ext) begin
         case (code)
            8'h1C: ascii_of = base + 8'd0;
            8'h32: ascii_of = base + 8'd1;
            8'h21: ascii_of = base + 8'd2;
            8'h23: ascii_of = base + 8'd3;
            8'h24: ascii_of = base + 8'd4;
            8'h2B: ascii_of = base + 8'd5;
            8'h34: ascii_of = base + 8'd6;
            8'h33: ascii_of = base + 8'd7;
            8'h43: ascii_of = base + 8'd8;
            8'h3B: ascii_of = base + 8'd9;
            8'h42: ascii_of = base + 8'd10;
            8'h4B: ascii_of = base + 8'd11;
            8'h3A: ascii_of = base + 8'd12;
            8'h31: ascii_of = base + 8'd13;
            8'h44: ascii_of = base + 8'd14;
            8'h4D: ascii_of = base + 8'd15;
            8'h15: ascii_of = base + 8'd16;
            8'h2D: ascii_of = base + 8'd17;
            8'h1B: ascii_of = base + 8'd18;
            8'h2C: ascii_of = base + 8'd19;
            8'h3C: ascii_of = base + 8'd20;
            8'h2A: ascii_of = base + 8'd21;
            8'h1D: ascii_of = base + 8'd22;
            8'h22: ascii_of = base + 8'd23;
            8'h35: ascii_of = base + 8'd24;
            8'h1A: ascii_of = base + 8'd25;
            8'h45: ascii_of = 8'h30;
            8'h16: ascii_of = 8'h31;
            8'h1E: ascii_of = 8'h32;
            8'h26: ascii_of = 8'h33;
            8'h25: ascii_of = 8'h34;
            8'h2E: ascii_of = 8'h35;
            8'h36: ascii_of = 8'h36;
            8'h3D: ascii_of = 8'h37;
            8'h3E: ascii_of = 8'h38;
            8'h46: ascii_of = 8'h39;
            8'h29: ascii_of = 8'h20;
            8'h5A: ascii_of = 8'h0D;
            8'h66: ascii_of = 8'h08;
            default: ascii_of = 8'h00;
         endcase
      end
   endfunction

   assign same_key = (byte_q == key_code_q) && (ext_q == key_ext_q);

   always_comb begin
      state_d       = state_q;
      byte_d        = byte_q;
      brk_d         = brk_q;
      ext_d         = ext_q;
      nextdata_n_d  = 1'b1;
      key_code_d    = key_code_q;
      key_ext_d     = key_ext_q;
      key_ascii_d   = key_ascii_q;
      key_valid_d   = key_valid_q;
      press_count_d = press_count_q;
      overflow_d    = overflow_q | kb_overflow;

      case (state_q)
         S_IDLE: begin
            if (kb_ready) begin
               byte_d       = kb_data;
               nextdata_n_d = 1'b0;
               state_d      = S_PROC;
            end
         end
         S_PROC: begin
            state_d = S_WAIT;
            if (byte_q == BRK_CODE) begin
               brk_d = 1'b1;
            end else if (byte_q == EXT_CODE) begin
               ext_d = 1'b1;
            end else if (brk_q) begin
               if (same_key) key_valid_d = 1'b0;
               brk_d = 1'b0;
               ext_d = 1'b0;
            end else begin
               // A held key re-sent by typematic repeat is not a new press.
               if (!(key_valid_q && same_key)) begin
                  key_code_d    = byte_q;
                  key_ext_d     = ext_q;
                  key_valid_d   = 1'b1;
                  key_ascii_d   = ascii_of(byte_q, ext_q);
                  press_count_d = press_count_q + COUNT_W'(1);
               end
               ext_d = 1'b0;
            end
         end
         S_WAIT:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= S_IDLE;
         byte_q        <= 8'h00;
         brk_q         <= 1'b0;
         ext_q         <= 1'b0;
         nextdata_n_q  <= 1'b1;
         key_code_q    <= 8'h00;
         key_ext_q     <= 1'b0;
         key_ascii_q   <= 8'h00;
         key_valid_q   <= 1'b0;
         press_count_q <= '0;
         overflow_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         byte_q        <= byte_d;
         brk_q         <= brk_d;
         ext_q         <= ext_d;
         nextdata_n_q  <= nextdata_n_d;
         key_code_q    <= key_code_d;
         key_ext_q     <= key_ext_d;
         key_ascii_q   <= key_ascii_d;
         key_valid_q   <= key_valid_d;
         press_count_q <= press_count_d;
         overflow_q    <= overflow_d;
      end
   end

   assign kb_nextdata_n = nextdata_n_q;
   assign key_code      = key_code_q;
   assign key_ext       = key_ext_q;
   assign key_ascii     = key_ascii_q;
   assign key_valid     = key_valid_q;
   assign press_count   = press_count_q;
   assign overflow_seen = overflow_q;

endmodule

// File: tb/tb_kbd_scan_decoder.sv
// Directed bench for kbd_scan_decoder: a small FIFO model feeds scan codes and
// every observed output is asserted against hand-computed values.
module tb_kbd_scan_decoder;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] kb_data = 8'h00;
   logic       kb_ready = 1'b0;
   logic       kb_overflow = 1'b0;
   logic       kb_nextdata_n;
   logic [7:0] key_code;
   logic       key_ext;
   logic [7:0] key_ascii;
   logic       key_valid;
   logic [7:0] press_count;
   logic       overflow_seen;

   int         errors = 0;
   int         checks = 0;
   int         cyc = 0;
   int         strobes = 0;
   int         consec_low = 0;
   bit         prev_low = 1'b0;
   logic [7:0] fifo[$];
   int         strobe_cyc[$];

   kbd_scan_decoder #(.COUNT_W(8), .ASCII_UPPER(1'b0)) dut (
      .clk(clk), .rst(rst), .kb_data(kb_data), .kb_ready(kb_ready),
      .kb_overflow(kb_overflow), .kb_nextdata_n(kb_nextdata_n),
      .key_code(key_code), .key_ext(key_ext), .key_ascii(key_ascii),
      .key_valid(key_valid), .press_count(press_count), .overflow_seen(overflow_seen)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // FIFO model: a low strobe seen mid-cycle pops the head before the next edge.
   always @(negedge clk) begin
      if (kb_nextdata_n === 1'b0) begin
         if (prev_low) consec_low++;
         strobes++;
         strobe_cyc.push_back(cyc);
         if (fifo.size() != 0) void'(fifo.pop_front());
         prev_low = 1'b1;
      end else begin
         prev_low = 1'b0;
      end
      kb_ready = (fifo.size() != 0);
      kb_data  = (fifo.size() != 0) ? fifo[0] : 8'h00;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
      $display("check %-16s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic push(input logic [7:0] b);
      fifo.push_back(b);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((fifo.size() != 0 || kb_ready) && n < 5000) begin
         @(negedge clk);
         n++;
      end
      repeat (4) @(negedge clk);
      chk("drain_timeout", (n >= 5000) ? 32'd1 : 32'd0, 32'd0);
   endtask

   initial begin
      int s0;
      repeat (3) @(negedge clk);
      chk("rst_nextdata_n", kb_nextdata_n, 1);
      chk("rst_code", key_code, 8'h00);
      chk("rst_ascii", key_ascii, 8'h00);
      chk("rst_ext_valid", {key_ext, key_valid}, 2'b00);
      chk("rst_count", press_count, 0);
      chk("rst_ovf", overflow_seen, 0);
      rst = 1'b0;
      @(negedge clk);

      // Single press
      s0 = strobes;
      push(8'h1C); drain();
      chk("press_strobes", strobes - s0, 1);
      chk("press_code", key_code, 8'h1C);
      chk("press_ascii", key_ascii, 8'h61);
      chk("press_valid", key_valid, 1);
      chk("press_count", press_count, 1);

      // Release and re-press
      push(8'hF0); push(8'h1C); drain();
      chk("rel_valid", key_valid, 0);
      chk("rel_count", press_count, 1);
      chk("rel_code", key_code, 8'h1C);
      push(8'h1C); drain();
      chk("repress_count", press_count, 2);
      chk("repress_valid", key_valid, 1);

      // Typematic repeat then a foreign break
      push(8'h16); push(8'h16); push(8'h16); drain();
      chk("typ_code", key_code, 8'h16);
      chk("typ_ascii", key_ascii, 8'h31);
      chk("typ_count", press_count, 3);
      push(8'hF0); push(8'h1C); drain();
      chk("foreign_brk", key_valid, 1);
      chk("foreign_code", key_code, 8'h16);

      // Extended key press, extended release, then plain code
      push(8'hE0); push(8'h75); drain();
      chk("ext_flag", key_ext, 1);
      chk("ext_ascii", key_ascii, 8'h00);
      chk("ext_count", press_count, 4);
      push(8'hE0); push(8'hF0); push(8'h75); drain();
      chk("ext_rel_valid", key_valid, 0);
      push(8'h75); drain();
      chk("plain75_count", press_count, 5);
      chk("plain75_ext", key_ext, 0);
      chk("plain75_valid", key_valid, 1);

      // More lookup entries
      push(8'h1A); drain();
      chk("z_ascii", key_ascii, 8'h7A);
      push(8'h45); drain();
      chk("zero_ascii", key_ascii, 8'h30);
      push(8'h66); drain();
      chk("bksp_ascii", key_ascii, 8'h08);
      chk("lookup_count", press_count, 8);

      // 256 press/release pairs bring the counter back to the same value
      for (int i = 0; i < 256; i++) begin
         push(8'h2B); push(8'hF0); push(8'h2B);
      end
      drain();
      chk("wrap_count", press_count, 8);
      chk("wrap_code", key_code, 8'h2B);
      chk("wrap_ascii", key_ascii, 8'h66);
      chk("wrap_valid", key_valid, 0);

      // Overflow pulse is sticky
      kb_overflow = 1'b1; @(negedge clk); kb_overflow = 1'b0;
      @(negedge clk);
      chk("ovf_set", overflow_seen, 1);
      repeat (10) @(negedge clk);
      chk("ovf_sticky", overflow_seen, 1);

      // Reset between prefix bytes abandons the partial sequence
      push(8'hE0); push(8'hF0); drain();
      rst = 1'b1; #1;
      chk("async_rst_ovf", overflow_seen, 0);
      @(negedge clk); rst = 1'b0; @(negedge clk);
      chk("rst_mid_count", press_count, 0);
      push(8'h5A); drain();
      chk("fresh_ext", key_ext, 0);
      chk("fresh_ascii", key_ascii, 8'h0D);
      chk("fresh_valid", key_valid, 1);
      chk("fresh_count", press_count, 1);

      // Back-to-back: four preloaded bytes
      s0 = strobes;
      strobe_cyc.delete();
      push(8'h1C); push(8'hF0); push(8'h1C); push(8'h32); drain();
      chk("b2b_strobes", strobes - s0, 4);
      for (int i = 1; i < 4; i++) begin
         if (strobe_cyc.size() > i)
            chk("b2b_spacing", strobe_cyc[i] - strobe_cyc[i-1], 3);
      end
      chk("b2b_code", key_code, 8'h32);
      chk("b2b_ascii", key_ascii, 8'h62);
      chk("b2b_count", press_count, 3);
      chk("no_consec_low", consec_low, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
